bus_wait_slave: RTL and testbench
=================================

# bus_wait_slave

Generic bus responder for the shared slave-side bus: decodes one chip-select's transactions into an 8-word register bank, inserts a fixed number of wait states, and answers with a one-cycle active-low ready pulse and read data. It sits behind the address decoder as the slave end of the protocol driven by the master-side multiplexer. It is the team's reference responder for modelling slow peripherals and for exercising master stall paths.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: wait states between request sample and ready; 0 allowed.
- `REG_ADDR_W`, default 3: register index width; bank depth is 2^REG_ADDR_W.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cs_` in 1: chip select from the address decoder, active low.
- `as_` in 1: address strobe, active low.
- `rw` in 1: `READ`=1, `WRITE`=0 (codebase encodings).
- `addr` in `WORD_ADDR_W` (30): word address. Only `addr[REG_ADDR_W-1:0]` is decoded.
- `wr_data` in `WORD_DATA_W` (32): write data.
- `rd_data` out 32: read data. Valid only while `rdy_` is low, otherwise 0.
- `rdy_` out 1: ready, active low, registered, low for exactly one cycle per transaction.

## Operation
- FSM states: `IDLE`, `WAIT`, `ACK`.
- **IDLE**: at an edge where `cs_`=0 and `as_`=0, latch the index, `rw` and `wr_data`, and load the wait counter with `WAIT_CYCLES`.
  - Next state is `WAIT`, or `ACK` if `WAIT_CYCLES`=0.
- **WAIT**: decrement the counter each cycle. When it reaches 0, go to `ACK`.
  - If `cs_` or `as_` is high at any WAIT edge, abort to `IDLE`: no write, no ready.
- **ACK**: `rdy_`=0 for this cycle, then unconditionally return to `IDLE`.
  - `ACK` never samples a new request. The request may reappear in the following `IDLE` cycle (back-to-back is supported).
- Writes commit on the edge that enters `ACK`. Every later transaction sees the new value.
- Registers 0..(2^REG_ADDR_W−2) are plain read/write registers.
- The top index is a read-only access counter:
  - Writes to it are ignored, but ready is still returned.
  - It increments by 1 on the edge leaving `ACK`, for every completed read or write. It wraps 0xFFFF_FFFF→0.
  - A read of the counter returns its value before that access's increment.
- `rd_data` is driven in `ACK` from the latched index, for reads only. It is 0 for writes and in all other states.
- Reset, asynchronous at any time including mid-transaction:
  - state `IDLE`, `rdy_`=1, `rd_data`=0;
  - all registers and the counter = 0;
  - wait counter = 0.
  - A transaction interrupted by reset produces no write and no ready.

## Timing
- Request sampled at edge E0 (cycle 0). `rdy_` is low in cycle `WAIT_CYCLES`+1.
  - Default: request in cycle 0, waits in cycles 1–2, ready in cycle 3.
- Minimum transaction period is `WAIT_CYCLES`+2 cycles: the request cycle, the waits, `ACK`, then the next request in the following `IDLE` cycle.
- All outputs are register-driven. There is no combinational path from any input to `rdy_` or `rd_data`.
- Wait counter width is `$clog2(WAIT_CYCLES+1)`, minimum 1 bit.
- The master holds `addr`/`rw`/`wr_data` stable until it sees `rdy_`. The slave uses only its latched copies.

## Structure
- State encodings (`BWS_IDLE`/`BWS_WAIT`/`BWS_ACK`, 2 bits) and the state bus macro go in a new shared header, `head/bus_wait_slave.v`.
- The header reuses the existing bus, `ENABLE_`/`DISABLE_`, `READ`/`WRITE` and width definitions.
- One sub-module: `bus_wait_slave_regs`. It holds the register bank and access counter, with write-enable, index, data-in, increment and combinational read-out ports.
- The FSM and output registers stay in the top module.

## Test plan
- **Reset mid-wait**: write 0xDEADBEEF to index 2, then assert `reset` in cycle 1 → `rdy_`=1 and `rd_data`=0 immediately. A subsequent read of index 2 returns 0.
- **Default latency**: write 0x1234_5678 to index 1 with `WAIT_CYCLES`=2 → `rdy_` low only in cycle 3. Read index 1 next → `rdy_` low 3 cycles after its request, `rd_data`=0x1234_5678 in that cycle only.
- **Zero wait**: with `WAIT_CYCLES`=0, a read of index 0 after reset → `rdy_` low in cycle 1 with `rd_data`=0. Three back-to-back reads give `rdy_` low in cycles 1, 3 and 5.
- **Abort**: raise `cs_` in cycle 1 of a write of 0xAAAA_0001 to index 3 → no `rdy_` pulse. A following read of index 3 returns 0.
- **Counter**: after 5 completed accesses, read index 7 → 5. Write 0xFFFF_FFFF to index 7 → `rdy_` pulses, and a following read returns 7.
- **Wrap**: force the counter to 0xFFFF_FFFF via hierarchical deposit, then complete one access → the next read of index 7 returns 0.

Source files
------------

// File: rtl/bus_wait_slave_pkg.sv
// Shared definitions for the wait-state bus responder: bus widths, active-low
// and read/write encodings, FSM state type and wait-counter sizing.
package bus_wait_slave_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  typedef enum logic [1:0] {
    BWS_IDLE = 2'd0,
    BWS_WAIT = 2'd1,
    BWS_ACK  = 2'd2
  } bws_state_e;

  // A zero-wait configuration still needs a 1-bit counter to declare.
  function automatic int wait_cnt_w(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_wait_slave_if.sv
// Slave-side shared bus: active-low select/strobe/ready, word address, data.
interface bus_wait_slave_if;
  import bus_wait_slave_pkg::*;

  logic       cs_;
  logic       as_;
  logic       rw;
  word_addr_t addr;
  word_data_t wr_data;
  word_data_t rd_data;
  logic       rdy_;

  modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
  modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);

endinterface

// File: rtl/bus_wait_slave_regs.sv
// Register bank for the bus responder: plain R/W registers plus a read-only
// access counter at the top index, with a combinational read port.
module bus_wait_slave_regs
  import bus_wait_slave_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] idx,
  input  word_data_t            din,
  input  logic                  inc,
  input  logic [REG_ADDR_W-1:0] rd_idx,
  output word_data_t            dout
);

  localparam int                    DEPTH   = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] CNT_IDX = '1;

  word_data_t bank_q [DEPTH-1];
  word_data_t cnt_q;

  // NOTE: the bank is cleared by reset because software relies on registers
  // reading 0 after reset; a bank without that guarantee would skip the reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH - 1; i++) bank_q[i] <= '0;
    end else if (we && idx != CNT_IDX) begin
      bank_q[idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt_q <= '0;
    else if (inc) cnt_q <= cnt_q + word_data_t'(1);
  end

  assign dout = (rd_idx == CNT_IDX) ? cnt_q : bank_q[rd_idx];

endmodule

// File: rtl/bus_wait_slave.sv
// Wait-state bus responder: samples a request, waits WAIT_CYCLES cycles, then
// returns a one-cycle active-low ready with read data from the register bank.
module bus_wait_slave
  import bus_wait_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int REG_ADDR_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  bus_wait_slave_if.slave  bus
);

  localparam int             CNT_W     = wait_cnt_w(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  bws_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  latch;
  logic [REG_ADDR_W-1:0] idx_q;
  logic                  rw_q;
  word_data_t            data_q;
  logic                  rdy_q;
  word_data_t            rd_data_q;

  logic                  req;
  logic                  enter_ack;
  logic [REG_ADDR_W-1:0] cur_idx;
  logic                  cur_rw;
  word_data_t            cur_data;
  word_data_t            reg_dout;
  logic                  unused_addr;

  assign req         = (bus.cs_ == ENABLE_) && (bus.as_ == ENABLE_);
  assign unused_addr = ^bus.addr[WORD_ADDR_W-1:REG_ADDR_W];

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      BWS_IDLE: begin
        if (req) begin
          latch   = 1'b1;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? BWS_ACK : BWS_WAIT;
        end
      end
      BWS_WAIT: begin
        if (!req) begin
          state_d = BWS_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = BWS_ACK;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      BWS_ACK:  state_d = BWS_IDLE;
      default:  state_d = BWS_IDLE;
    endcase
  end

  // With zero waits the commit edge is the sampling edge, so the live bus is
  // used there; otherwise the latched copy is.
  assign cur_idx   = (state_q == BWS_IDLE) ? bus.addr[REG_ADDR_W-1:0] : idx_q;
  assign cur_rw    = (state_q == BWS_IDLE) ? bus.rw : rw_q;
  assign cur_data  = (state_q == BWS_IDLE) ? bus.wr_data : data_q;
  assign enter_ack = (state_d == BWS_ACK);

  bus_wait_slave_regs #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regs (
    .clk    (clk),
    .reset  (reset),
    .we     (enter_ack && cur_rw == WRITE),
    .idx    (cur_idx),
    .din    (cur_data),
    .inc    (state_q == BWS_ACK),
    .rd_idx (cur_idx),
    .dout   (reg_dout)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BWS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      rw_q   <= WRITE;
      data_q <= '0;
    end else if (latch) begin
      idx_q  <= bus.addr[REG_ADDR_W-1:0];
      rw_q   <= bus.rw;
      data_q <= bus.wr_data;
    end
  end

  // Outputs are registered on the edge entering ACK, so a counter read
  // returns its value before this access's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q     <= DISABLE_;
      rd_data_q <= '0;
    end else begin
      rdy_q     <= enter_ack ? ENABLE_ : DISABLE_;
      rd_data_q <= (enter_ack && cur_rw == READ) ? reg_dout : '0;
    end
  end

  assign bus.rdy_    = rdy_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_wait_slave.sv
// Bench for bus_wait_slave: one instance with two wait states, one with none,
// a vector table of transactions and a read-data scoreboard per instance.
module tb_bus_wait_slave;
  import bus_wait_slave_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_wait_slave_if bus2 ();
  bus_wait_slave_if bus0 ();

  bus_wait_slave #(.WAIT_CYCLES(2), .REG_ADDR_W(3)) dut2 (
    .clk (clk), .reset (reset), .bus (bus2.slave)
  );
  bus_wait_slave #(.WAIT_CYCLES(0), .REG_ADDR_W(3)) dut0 (
    .clk (clk), .reset (reset), .bus (bus0.slave)
  );

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wd;
    int          abort_cyc;
    logic [31:0] exp;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q2[$];
  logic [31:0] q0[$];
  vec_t        vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel0, input logic cs, input logic as_n, input logic rw,
                         input logic [29:0] addr, input logic [31:0] wd);
    if (sel0) begin
      bus0.cs_ = cs; bus0.as_ = as_n; bus0.rw = rw; bus0.addr = addr; bus0.wr_data = wd;
    end else begin
      bus2.cs_ = cs; bus2.as_ = as_n; bus2.rw = rw; bus2.addr = addr; bus2.wr_data = wd;
    end
  endtask

  task automatic idle(input bit sel0);
    set_req(sel0, DISABLE_, DISABLE_, READ, 30'd0, 32'd0);
  endtask

  function automatic logic get_rdy(input bit sel0);
    return sel0 ? bus0.rdy_ : bus2.rdy_;
  endfunction

  function automatic logic [31:0] get_rd(input bit sel0);
    return sel0 ? bus0.rd_data : bus2.rd_data;
  endfunction

  // Scoreboard: every ready pulse pops one expected read value.
  always @(negedge clk) begin
    if (bus2.rdy_ === 1'b0) begin
      if (q2.size() == 0) check("spurious_rdy_w2", 32'(bus2.rdy_), 32'd1);
      else                check("sb_rd_w2", bus2.rd_data, q2.pop_front());
    end
    if (bus0.rdy_ === 1'b0) begin
      if (q0.size() == 0) check("spurious_rdy_w0", 32'(bus0.rdy_), 32'd1);
      else                check("sb_rd_w0", bus0.rd_data, q0.pop_front());
    end
  end

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the IDLE
  // cycle after the ready pulse (or after the abort window).
  task automatic do_txn(input bit sel0, input logic rw, input logic [29:0] addr,
                        input logic [31:0] wd, input int abort_cyc,
                        input logic [31:0] exp, input string name);
    int w   = sel0 ? 0 : 2;
    int lat = 0;
    set_req(sel0, ENABLE_, ENABLE_, rw, addr, wd);
    if (abort_cyc == 0) begin
      if (sel0) q0.push_back(exp);
      else      q2.push_back(exp);
    end
    for (int k = 1; k <= w + 4 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (abort_cyc != 0 && k == abort_cyc)
        set_req(sel0, DISABLE_, ENABLE_, rw, addr, wd);
      if (get_rdy(sel0) === 1'b0) lat = k;
    end
    idle(sel0);
    if (abort_cyc == 0) begin
      check({name, "_latency"}, 32'(lat), 32'(w + 1));
      @(posedge clk); #1;
      check({name, "_rdy_after"}, 32'(get_rdy(sel0)), 32'd1);
      check({name, "_rd_after"}, get_rd(sel0), 32'd0);
    end else begin
      check({name, "_abort_no_rdy"}, 32'(lat), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{WRITE, 30'd1,         32'h1234_5678, 0, 32'h0000_0000};
    vecs[1]  = '{READ,  30'h2AAA_AAA9, 32'h0000_0000, 0, 32'h1234_5678};
    vecs[2]  = '{WRITE, 30'd3,         32'hAAAA_0001, 1, 32'h0000_0000};
    vecs[3]  = '{READ,  30'd3,         32'h0000_0000, 0, 32'h0000_0000};
    vecs[4]  = '{WRITE, 30'd0,         32'hA5A5_0F0F, 0, 32'h0000_0000};
    vecs[5]  = '{READ,  30'd0,         32'h0000_0000, 0, 32'hA5A5_0F0F};
    vecs[6]  = '{READ,  30'd7,         32'h0000_0000, 0, 32'd5};
    vecs[7]  = '{WRITE, 30'd7,         32'hFFFF_FFFF, 0, 32'h0000_0000};
    vecs[8]  = '{READ,  30'd7,         32'h0000_0000, 0, 32'd7};
    vecs[9]  = '{WRITE, 30'h1555_5556, 32'h0000_0001, 0, 32'h0000_0000};
    vecs[10] = '{READ,  30'd6,         32'h0000_0000, 0, 32'h0000_0001};
    vecs[11] = '{READ,  30'd5,         32'h0000_0000, 0, 32'h0000_0000};
    vecs[12] = '{READ,  30'd1,         32'h0000_0000, 0, 32'h1234_5678};

    idle(1'b0);
    idle(1'b1);
    reset = 1'b1;
    #1;
    check("reset_rdy_w2", 32'(bus2.rdy_), 32'd1);
    check("reset_rd_w2", bus2.rd_data, 32'd0);
    check("reset_rdy_w0", 32'(bus0.rdy_), 32'd1);
    check("reset_rd_w0", bus0.rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_rdy_w2", 32'(bus2.rdy_), 32'd1);

    // Zero-wait instance: single read, then three back-to-back reads.
    do_txn(1'b1, READ, 30'd0, 32'd0, 0, 32'd0, "zw_rd0");
    repeat (3) q0.push_back(32'd0);
    set_req(1'b1, ENABLE_, ENABLE_, READ, 30'd0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 5) idle(1'b1);
      check($sformatf("b2b_rdy_c%0d", c), 32'(bus0.rdy_), (c % 2 == 1) ? 32'd0 : 32'd1);
    end

    for (int i = 0; i < 13; i++)
      do_txn(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].abort_cyc,
             vecs[i].exp, $sformatf("vec%0d", i));

    // Counter wrap through a deposited all-ones value.
    dut2.u_regs.cnt_q = 32'hFFFF_FFFF;
    do_txn(1'b0, READ, 30'd7, 32'd0, 0, 32'hFFFF_FFFF, "wrap_pre");
    do_txn(1'b0, READ, 30'd7, 32'd0, 0, 32'd0, "wrap_post");

    // Reset in the first wait cycle of a write.
    set_req(1'b0, ENABLE_, ENABLE_, WRITE, 30'd2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1'b0);
    #1;
    check("rst_mid_rdy", 32'(bus2.rdy_), 32'd1);
    check("rst_mid_rd", bus2.rd_data, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    do_txn(1'b0, READ, 30'd7, 32'd0, 0, 32'd0, "rst_cnt");
    do_txn(1'b0, READ, 30'd2, 32'd0, 0, 32'd0, "rst_rd2");

    // Reset while ready is asserted must clear the outputs at once.
    do_txn(1'b1, WRITE, 30'd4, 32'h0000_0077, 0, 32'd0, "zw_wr4");
    q0.push_back(32'h0000_0077);
    set_req(1'b1, ENABLE_, ENABLE_, READ, 30'd4, 32'd0);
    @(posedge clk); #1;
    idle(1'b1);
    check("ack_rdy_low", 32'(bus0.rdy_), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_ack_rdy", 32'(bus0.rdy_), 32'd1);
    check("rst_ack_rd", bus0.rd_data, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    do_txn(1'b1, READ, 30'd4, 32'd0, 0, 32'd0, "zw_rd4_after_rst");

    check("sb_drain_w2", 32'(q2.size()), 32'd0);
    check("sb_drain_w0", 32'(q0.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
